// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the sequencing control unit: ALU op codes, opcode,
// write-source and FSM enums, and the decoded-instruction struct.
package ctrl_seq_pkg;

   localparam logic [2:0] kLSH = 3'd0;
   localparam logic [2:0] kRSH = 3'd1;
   localparam logic [2:0] kXOR = 3'd2;
   localparam logic [2:0] kRXR = 3'd3;
   localparam logic [2:0] kORR = 3'd4;
   localparam logic [2:0] kADD = 3'd5;
   localparam logic [2:0] kSUB = 3'd6;

   typedef enum logic [3:0] {
      OP_LSL_0  = 4'b0000,
      OP_LSL_1  = 4'b0001,
      OP_LSR_0  = 4'b0010,
      OP_LSR_1  = 4'b0011,
      OP_LDR    = 4'b0100,
      OP_STR    = 4'b0101,
      OP_XOR    = 4'b0110,
      OP_RXR    = 4'b0111,
      OP_JE     = 4'b1000,
      OP_JNE    = 4'b1001,
      OP_MOVL   = 4'b1010,
      OP_MOVM   = 4'b1011,
      OP_NOP    = 4'b1100,
      OP_ORR    = 4'b1101,
      OP_ADDSUB = 4'b1110,
      OP_EXT    = 4'b1111
   } op_t;

   typedef enum logic [2:0] {
      WS_ALU  = 3'b000,
      WS_MEM  = 3'b001,
      WS_LLUT = 3'b010,
      WS_MLUT = 3'b011,
      WS_PC   = 3'b100
   } wsrc_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      LDWAIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Register fields are the raw 3-bit ISA fields; the *_shamt flags select
   // the shift-amount register instead, resolved to RAW bits by the top.
   typedef struct packed {
      logic       alu_class;
      logic       lut;
      logic       ldr;
      logic       str;
      logic       je;
      logic       jne;
      logic       halt;
      logic       a_shamt;
      logic       b_shamt;
      logic [2:0] alu_op;
      logic [2:0] addr_a;
      logic [2:0] addr_b;
      logic [2:0] addr_w;
      wsrc_t      wsrc;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps a machine word onto the decoded
// control struct; carries no state and applies no FSM gating.
module ctrl_decode
   import ctrl_seq_pkg::*;
#(
   parameter int IW = 9
) (
   input  logic [IW-1:0] instruction,
   output dec_t          dec
);

   op_t        op;
   logic [2:0] mid_reg;
   logic [2:0] hi_reg;

   assign op      = op_t'(instruction[IW-1:IW-4]);
   assign mid_reg = instruction[4:2];
   assign hi_reg  = {1'b1, instruction[1:0]};

   always_comb begin
      dec      = '0;
      dec.wsrc = WS_ALU;
      unique case (op)
         OP_LSL_0, OP_LSL_1, OP_LSR_0, OP_LSR_1: begin
            dec.alu_class = 1'b1;
            dec.alu_op    = (op == OP_LSR_0 || op == OP_LSR_1) ? kRSH : kLSH;
            dec.addr_w    = instruction[5:3];
            dec.a_shamt   = 1'b1;
            dec.addr_b    = instruction[2:0];
         end
         OP_XOR: begin
            dec.alu_class = 1'b1;
            dec.alu_op    = kXOR;
            dec.addr_a    = mid_reg;
            dec.b_shamt   = 1'b1;
            dec.addr_w    = mid_reg;
         end
         OP_RXR: begin
            dec.alu_class = 1'b1;
            dec.alu_op    = kRXR;
            dec.addr_a    = mid_reg;
            dec.addr_w    = mid_reg;
         end
         OP_ORR: begin
            dec.alu_class = 1'b1;
            dec.alu_op    = kORR;
            dec.addr_a    = mid_reg;
            dec.addr_b    = hi_reg;
            dec.addr_w    = mid_reg;
         end
         OP_ADDSUB: begin
            dec.alu_class = 1'b1;
            dec.alu_op    = instruction[1] ? kSUB : kADD;
            dec.addr_a    = mid_reg;
            dec.b_shamt   = 1'b1;
            dec.addr_w    = mid_reg;
         end
         OP_LDR: begin
            dec.ldr    = 1'b1;
            dec.addr_w = mid_reg;
            dec.addr_a = hi_reg;
         end
         OP_STR: begin
            dec.str    = 1'b1;
            dec.addr_a = mid_reg;
            dec.addr_b = hi_reg;
         end
         OP_JE:  dec.je  = 1'b1;
         OP_JNE: dec.jne = 1'b1;
         OP_MOVL: begin
            dec.lut    = 1'b1;
            dec.wsrc   = WS_LLUT;
            dec.addr_w = mid_reg;
         end
         OP_MOVM: begin
            dec.lut    = 1'b1;
            dec.wsrc   = WS_MLUT;
            dec.addr_w = mid_reg;
         end
         OP_EXT:  dec.halt = &instruction;
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Sequencing control unit: run/idle/done FSM with multi-cycle load wait,
// latched zero flag for conditional jumps, and gating of decoded controls.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int IW        = 9,
   parameter int RAW       = 3,
   parameter int MEM_LAT   = 2,
   parameter int SHAMT_REG = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [IW-1:0]  Instruction,
   input  logic           AluZero,
   output logic           PcEn,
   output logic           JumpTaken,
   output logic           RegWrEn,
   output logic           MemWrEn,
   output logic           MemRdEn,
   output logic [2:0]     WriteSource,
   output logic [RAW-1:0] ReadRegAddrA,
   output logic [RAW-1:0] ReadRegAddrB,
   output logic [RAW-1:0] WriteRegAddr,
   output logic [2:0]     ALUOp,
   output logic           Busy,
   output logic           Ack
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t         state;
   logic           zero_flag;
   logic [LAT_W-1:0] lat_cnt;
   dec_t           dec;
   wsrc_t          ws;
   logic [RAW-1:0] addr_a;
   logic [RAW-1:0] addr_b;
   logic [RAW-1:0] addr_w;

   ctrl_decode #(.IW(IW)) u_decode (
      .instruction (Instruction),
      .dec         (dec)
   );

   assign addr_a = dec.a_shamt ? RAW'(SHAMT_REG) : RAW'(dec.addr_a);
   assign addr_b = dec.b_shamt ? RAW'(SHAMT_REG) : RAW'(dec.addr_b);
   assign addr_w = RAW'(dec.addr_w);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         zero_flag <= 1'b0;
         lat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (Start) state <= RUN;
            RUN: begin
               if (dec.alu_class) zero_flag <= AluZero;
               if (dec.ldr) begin
                  lat_cnt <= LAT_LOAD;
                  if (MEM_LAT > 1) state <= LDWAIT;
               end else if (dec.halt) begin
                  state <= DONE;
               end
            end
            LDWAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt == LAT_W'(1)) state <= RUN;
            end
            DONE: if (Start) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Register fields follow the held instruction in RUN and LDWAIT only, so
   // the unit presents all-zero controls whenever no program is executing.
   always_comb begin
      PcEn         = 1'b0;
      JumpTaken    = 1'b0;
      RegWrEn      = 1'b0;
      MemWrEn      = 1'b0;
      MemRdEn      = 1'b0;
      ws           = WS_ALU;
      ReadRegAddrA = '0;
      ReadRegAddrB = '0;
      WriteRegAddr = '0;
      ALUOp        = 3'd0;
      Busy         = 1'b0;
      Ack          = 1'b0;
      case (state)
         RUN: begin
            Busy         = 1'b1;
            ReadRegAddrA = addr_a;
            ReadRegAddrB = addr_b;
            WriteRegAddr = addr_w;
            ALUOp        = dec.alu_op;
            if (dec.ldr) begin
               MemRdEn = 1'b1;
               if (MEM_LAT == 1) begin
                  RegWrEn = 1'b1;
                  ws      = WS_MEM;
                  PcEn    = 1'b1;
               end
            end else begin
               RegWrEn   = dec.alu_class | dec.lut;
               MemWrEn   = dec.str;
               ws        = dec.wsrc;
               PcEn      = ~dec.halt;
               JumpTaken = (dec.je & zero_flag) | (dec.jne & ~zero_flag);
            end
         end
         LDWAIT: begin
            Busy         = 1'b1;
            ReadRegAddrA = addr_a;
            ReadRegAddrB = addr_b;
            WriteRegAddr = addr_w;
            MemRdEn      = 1'b1;
            if (lat_cnt == LAT_W'(1)) begin
               RegWrEn = 1'b1;
               ws      = WS_MEM;
               PcEn    = 1'b1;
            end
         end
         DONE:    Ack = 1'b1;
         default: ;
      endcase
   end

   assign WriteSource = ws;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed test-plan steps followed by a
// randomized run, all compared against a cycle-level reference model.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   localparam int MEM_LAT = 3;

   typedef struct packed {
      logic       pcEn;
      logic       jumpTaken;
      logic       regWrEn;
      logic       memWrEn;
      logic       memRdEn;
      logic [2:0] writeSource;
      logic [2:0] addrA;
      logic [2:0] addrB;
      logic [2:0] addrW;
      logic [2:0] aluOp;
      logic       busy;
      logic       ack;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       startIn;
   logic       aluZero;
   logic [8:0] instruction;
   logic       pcEn, jumpTaken, regWrEn, memWrEn, memRdEn, busy, ack;
   logic [2:0] writeSource, addrA, addrB, addrW, aluOp;

   int    checks = 0;
   int    errors = 0;
   bit    running, finished, zFlag;
   int    loadCycles;
   outs_t lastObs, lastExp;

   ctrl_seq #(.IW(9), .RAW(3), .MEM_LAT(MEM_LAT), .SHAMT_REG(4)) dut (
      .Clk          (clk),
      .Reset        (reset),
      .Start        (startIn),
      .Instruction  (instruction),
      .AluZero      (aluZero),
      .PcEn         (pcEn),
      .JumpTaken    (jumpTaken),
      .RegWrEn      (regWrEn),
      .MemWrEn      (memWrEn),
      .MemRdEn      (memRdEn),
      .WriteSource  (writeSource),
      .ReadRegAddrA (addrA),
      .ReadRegAddrB (addrB),
      .WriteRegAddr (addrW),
      .ALUOp        (aluOp),
      .Busy         (busy),
      .Ack          (ack)
   );

   always #5 clk = ~clk;

   function automatic bit isAluClass(input logic [3:0] op);
      return (op[3:2] == 2'b00) || op == 4'b0110 || op == 4'b0111 ||
             op == 4'b1101 || op == 4'b1110;
   endfunction

   // Expected outputs for this cycle, derived from the ISA table and the
   // program-level situation (stopped, finished, or n cycles into a load).
   function automatic outs_t modelOutputs(input logic [8:0] ins);
      outs_t      e = '0;
      logic [3:0] op = ins[8:5];
      logic [2:0] mid = ins[4:2];
      logic [2:0] hi = {1'b1, ins[1:0]};
      if (finished) begin
         e.ack = 1'b1;
         return e;
      end
      if (!running) return e;
      e.busy = 1'b1;
      if (ins == 9'h1FF) return e;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
            e.aluOp = (op[1] == 1'b1) ? kRSH : kLSH;
            e.addrW = ins[5:3]; e.addrA = 3'd4; e.addrB = ins[2:0];
            e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b0110: begin
            e.aluOp = kXOR; e.addrA = mid; e.addrB = 3'd4; e.addrW = mid;
            e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b0111: begin
            e.aluOp = kRXR; e.addrA = mid; e.addrW = mid;
            e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b1101: begin
            e.aluOp = kORR; e.addrA = mid; e.addrB = hi; e.addrW = mid;
            e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b1110: begin
            e.aluOp = ins[1] ? kSUB : kADD; e.addrA = mid; e.addrB = 3'd4;
            e.addrW = mid; e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b0100: begin
            e.memRdEn = 1'b1; e.addrW = mid; e.addrA = hi;
            if (loadCycles + 1 == MEM_LAT) begin
               e.regWrEn = 1'b1; e.writeSource = 3'b001; e.pcEn = 1'b1;
            end
         end
         4'b0101: begin
            e.memWrEn = 1'b1; e.addrA = mid; e.addrB = hi; e.pcEn = 1'b1;
         end
         4'b1000: begin e.pcEn = 1'b1; e.jumpTaken = zFlag; end
         4'b1001: begin e.pcEn = 1'b1; e.jumpTaken = !zFlag; end
         4'b1010: begin
            e.writeSource = 3'b010; e.addrW = mid; e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         4'b1011: begin
            e.writeSource = 3'b011; e.addrW = mid; e.regWrEn = 1'b1; e.pcEn = 1'b1;
         end
         default: e.pcEn = 1'b1;
      endcase
      return e;
   endfunction

   task automatic updateModel(input logic [8:0] ins, input logic start, input logic az);
      if (!running) begin
         if (start) begin
            running  = 1'b1;
            finished = 1'b0;
         end
      end else if (ins == 9'h1FF) begin
         running  = 1'b0;
         finished = 1'b1;
      end else if (ins[8:5] == 4'b0100) begin
         loadCycles++;
         if (loadCycles == MEM_LAT) loadCycles = 0;
      end else if (isAluClass(ins[8:5])) begin
         zFlag = az;
      end
   endtask

   task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string step);
      checkField({step, ".PcEn"}, 8'(lastObs.pcEn), 8'(lastExp.pcEn));
      checkField({step, ".JumpTaken"}, 8'(lastObs.jumpTaken), 8'(lastExp.jumpTaken));
      checkField({step, ".RegWrEn"}, 8'(lastObs.regWrEn), 8'(lastExp.regWrEn));
      checkField({step, ".MemWrEn"}, 8'(lastObs.memWrEn), 8'(lastExp.memWrEn));
      checkField({step, ".MemRdEn"}, 8'(lastObs.memRdEn), 8'(lastExp.memRdEn));
      checkField({step, ".WriteSource"}, 8'(lastObs.writeSource), 8'(lastExp.writeSource));
      checkField({step, ".AddrA"}, 8'(lastObs.addrA), 8'(lastExp.addrA));
      checkField({step, ".AddrB"}, 8'(lastObs.addrB), 8'(lastExp.addrB));
      checkField({step, ".AddrW"}, 8'(lastObs.addrW), 8'(lastExp.addrW));
      checkField({step, ".ALUOp"}, 8'(lastObs.aluOp), 8'(lastExp.aluOp));
      checkField({step, ".Busy"}, 8'(lastObs.busy), 8'(lastExp.busy));
      checkField({step, ".Ack"}, 8'(lastObs.ack), 8'(lastExp.ack));
   endtask

   task automatic sampleAndCheck(input string step, input logic [8:0] ins);
      lastExp = modelOutputs(ins);
      lastObs = '{pcEn, jumpTaken, regWrEn, memWrEn, memRdEn, writeSource,
                  addrA, addrB, addrW, aluOp, busy, ack};
      checkOutput(step);
   endtask

   task automatic applyStimulus(input string step, input logic [8:0] ins,
                                input logic start, input logic az);
      @(negedge clk);
      instruction = ins;
      startIn     = start;
      aluZero     = az;
      #1;
      sampleAndCheck(step, ins);
      @(posedge clk);
      updateModel(ins, start, az);
   endtask

   task automatic applyReset(input string step);
      @(negedge clk);
      reset      = 1'b1;
      running    = 1'b0;
      finished   = 1'b0;
      zFlag      = 1'b0;
      loadCycles = 0;
      #1;
      sampleAndCheck(step, instruction);
      @(negedge clk);
      #1;
      sampleAndCheck(step, instruction);
      reset = 1'b0;
   endtask

   initial begin
      logic [8:0] curIns;
      reset = 1'b1; startIn = 1'b0; aluZero = 1'b0; instruction = 9'b0100_010_01;

      applyReset("por");
      applyStimulus("idle", 9'b0100_010_01, 1'b0, 1'b0);
      checkField("idle.PcEn", 8'(lastObs.pcEn), 8'd0);

      // Start a load and reset it in its final wait cycle.
      applyStimulus("start1", 9'b0100_010_01, 1'b1, 1'b0);
      applyStimulus("ldr_a1", 9'b0100_010_01, 1'b0, 1'b0);
      applyStimulus("ldr_a2", 9'b0100_010_01, 1'b0, 1'b0);
      applyReset("rst_ldwait");
      checkField("rst_ldwait.RegWrEn", 8'(lastObs.regWrEn), 8'd0);
      applyStimulus("idle2", 9'b1110_011_00, 1'b0, 1'b0);
      checkField("idle2.RegWrEn", 8'(lastObs.regWrEn), 8'd0);
      applyStimulus("start2", 9'b1110_011_00, 1'b1, 1'b0);

      applyStimulus("add", 9'b1110_011_00, 1'b0, 1'b0);
      checkField("add.RegWrEn", 8'(lastObs.regWrEn), 8'd1);
      checkField("add.ALUOp", 8'(lastObs.aluOp), 8'(kADD));
      checkField("add.AddrW", 8'(lastObs.addrW), 8'd3);
      checkField("add.AddrB", 8'(lastObs.addrB), 8'd4);
      checkField("add.PcEn", 8'(lastObs.pcEn), 8'd1);

      for (int c = 1; c <= MEM_LAT; c++) begin
         applyStimulus("ldr", 9'b0100_010_01, 1'b0, 1'b0);
         checkField("ldr.MemRdEn", 8'(lastObs.memRdEn), 8'd1);
         checkField("ldr.PcEn", 8'(lastObs.pcEn), (c == MEM_LAT) ? 8'd1 : 8'd0);
         checkField("ldr.RegWrEn", 8'(lastObs.regWrEn), (c == MEM_LAT) ? 8'd1 : 8'd0);
      end
      checkField("ldr.WriteSource", 8'(lastObs.writeSource), 8'd1);
      checkField("ldr.AddrW", 8'(lastObs.addrW), 8'd2);
      checkField("ldr.AddrA", 8'(lastObs.addrA), 8'd5);

      applyStimulus("xor_z1", 9'b0110_000_00, 1'b0, 1'b1);
      applyStimulus("je_z1", 9'b1000_00000, 1'b0, 1'b0);
      checkField("je_z1.JumpTaken", 8'(lastObs.jumpTaken), 8'd1);
      applyStimulus("jne_z1", 9'b1001_00000, 1'b0, 1'b0);
      checkField("jne_z1.JumpTaken", 8'(lastObs.jumpTaken), 8'd0);
      applyStimulus("xor_z0", 9'b0110_000_00, 1'b0, 1'b0);
      applyStimulus("je_z0", 9'b1000_00000, 1'b0, 1'b1);
      checkField("je_z0.JumpTaken", 8'(lastObs.jumpTaken), 8'd0);
      applyStimulus("jne_z0", 9'b1001_00000, 1'b0, 1'b1);
      checkField("jne_z0.JumpTaken", 8'(lastObs.jumpTaken), 8'd1);

      applyStimulus("str", 9'b0101_001_10, 1'b0, 1'b0);
      checkField("str.MemWrEn", 8'(lastObs.memWrEn), 8'd1);
      checkField("str.AddrA", 8'(lastObs.addrA), 8'd1);
      checkField("str.AddrB", 8'(lastObs.addrB), 8'd6);
      checkField("str.RegWrEn", 8'(lastObs.regWrEn), 8'd0);
      applyStimulus("after_str", 9'b1100_00000, 1'b0, 1'b0);
      checkField("after_str.MemWrEn", 8'(lastObs.memWrEn), 8'd0);

      for (int c = 0; c < 2 * MEM_LAT; c++)
         applyStimulus("ldr_b2b", (c < MEM_LAT) ? 9'b0100_111_11 : 9'b0100_000_00, 1'b0, 1'b0);

      applyStimulus("sub_start", 9'b1110_001_10, 1'b1, 1'b0);
      checkField("sub.ALUOp", 8'(lastObs.aluOp), 8'(kSUB));
      applyStimulus("after_start", 9'b0111_101_00, 1'b0, 1'b0);
      checkField("after_start.Busy", 8'(lastObs.busy), 8'd1);

      applyStimulus("halt", 9'h1FF, 1'b0, 1'b0);
      checkField("halt.PcEn", 8'(lastObs.pcEn), 8'd0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus("done", 9'($urandom_range(0, 511)), 1'b0, 1'($urandom_range(0, 1)));
         checkField("done.Ack", 8'(lastObs.ack), 8'd1);
         checkField("done.Busy", 8'(lastObs.busy), 8'd0);
      end
      applyStimulus("restart", 9'b1100_00000, 1'b1, 1'b0);
      applyStimulus("rerun", 9'b1100_00000, 1'b0, 1'b0);
      checkField("rerun.Ack", 8'(lastObs.ack), 8'd0);
      checkField("rerun.PcEn", 8'(lastObs.pcEn), 8'd1);

      // Random program: the word only changes once a load has completed.
      curIns = 9'($urandom_range(0, 510));
      for (int c = 0; c < 400; c++) begin
         applyStimulus("rand", curIns, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
         if (loadCycles == 0)
            curIns = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
